// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use bubble,
// halt/timeout handling and saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       D_ADDR1,
  input  logic [4:0]       D_ADDR2,
  input  logic             D_USES1,
  input  logic             D_USES2,
  input  logic [4:0]       E_WADDR,
  input  logic             E_MEM_READ,
  input  logic             E_REG_WRITE,
  input  logic             BR_TAKEN,
  input  logic             M_MEM_REQ,
  input  logic             M_MEM_ACK,
  input  logic             W_HALT,
  output logic             PC_EN,
  output logic             FD_EN,
  output logic             DE_EN,
  output logic             EM_EN,
  output logic             FD_FLUSH,
  output logic             DE_FLUSH,
  output logic             MW_FLUSH,
  output logic             HALTED,
  output logic             BUS_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [9:0] TIMEOUT_V = 10'(TIMEOUT);

  state_t           state, state_next;
  logic [9:0]       wait_cnt, wait_cnt_next;
  logic             bus_err, bus_err_next;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_stall, load_use, br_apply, stall_inc;

  assign mem_stall = M_MEM_REQ & ~M_MEM_ACK;
  assign load_use  = E_MEM_READ & E_REG_WRITE & (E_WADDR != 5'd0) &
                     ((D_USES1 & (D_ADDR1 == E_WADDR)) |
                      (D_USES2 & (D_ADDR2 == E_WADDR)));

  // A branch seen under a memory freeze is re-presented later, so it is not counted here.
  assign br_apply  = (state != HALT) & ~mem_stall & BR_TAKEN;
  assign stall_inc = (state != HALT) & ~PC_EN;

  always_comb begin
    PC_EN    = 1'b1;
    FD_EN    = 1'b1;
    DE_EN    = 1'b1;
    EM_EN    = 1'b1;
    FD_FLUSH = 1'b0;
    DE_FLUSH = 1'b0;
    MW_FLUSH = 1'b0;
    HALTED   = 1'b0;
    if (RST) begin
      {PC_EN, FD_EN, DE_EN, EM_EN} = 4'b0000;
      {FD_FLUSH, DE_FLUSH, MW_FLUSH} = 3'b111;
    end else if (state == HALT) begin
      {PC_EN, FD_EN, DE_EN, EM_EN} = 4'b0000;
      HALTED = 1'b1;
    end else if (mem_stall) begin
      {PC_EN, FD_EN, DE_EN, EM_EN} = 4'b0000;
      MW_FLUSH = 1'b1;
    end else if (BR_TAKEN) begin
      FD_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end else if (load_use) begin
      PC_EN    = 1'b0;
      FD_EN    = 1'b0;
      DE_FLUSH = 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    bus_err_next  = bus_err;
    case (state)
      RUN: begin
        if (W_HALT) begin
          state_next = HALT;
        end else if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 10'd1;
        end
      end
      MEM_WAIT: begin
        if (W_HALT) begin
          state_next = HALT;
        end else if (mem_stall) begin
          if (wait_cnt == TIMEOUT_V) begin
            state_next   = HALT;
            bus_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt + 10'd1;
          end
        end else begin
          state_next    = RUN;
          wait_cnt_next = 10'd0;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 10'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= 10'd0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      bus_err  <= bus_err_next;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (br_apply && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign BUS_ERR   = bus_err;
  assign STALL_CNT = stall_cnt;
  assign FLUSH_CNT = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4, CNT_W=4 so timeout
// and counter saturation are reachable in a few cycles).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_addr1, d_addr2, e_waddr;
  logic       d_uses1, d_uses2, e_mem_read, e_reg_write;
  logic       br_taken, m_mem_req, m_mem_ack, w_halt;
  logic       pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_flush;
  logic       halted, bus_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [8:0] status;

  int vectors = 0;
  int miscompares = 0;

  // {PC_EN,FD_EN,DE_EN,EM_EN, FD_FLUSH,DE_FLUSH,MW_FLUSH, HALTED, BUS_ERR}
  localparam logic [8:0] V_RST  = 9'b0000_111_0_0;
  localparam logic [8:0] V_RUN  = 9'b1111_000_0_0;
  localparam logic [8:0] V_LU   = 9'b0011_010_0_0;
  localparam logic [8:0] V_BR   = 9'b1111_110_0_0;
  localparam logic [8:0] V_MEM  = 9'b0000_001_0_0;
  localparam logic [8:0] V_HALT = 9'b0000_000_1_0;
  localparam logic [8:0] V_ERR  = 9'b0000_000_1_1;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst),
    .D_ADDR1(d_addr1), .D_ADDR2(d_addr2), .D_USES1(d_uses1), .D_USES2(d_uses2),
    .E_WADDR(e_waddr), .E_MEM_READ(e_mem_read), .E_REG_WRITE(e_reg_write),
    .BR_TAKEN(br_taken), .M_MEM_REQ(m_mem_req), .M_MEM_ACK(m_mem_ack), .W_HALT(w_halt),
    .PC_EN(pc_en), .FD_EN(fd_en), .DE_EN(de_en), .EM_EN(em_en),
    .FD_FLUSH(fd_flush), .DE_FLUSH(de_flush), .MW_FLUSH(mw_flush),
    .HALTED(halted), .BUS_ERR(bus_err), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  assign status = {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_flush, halted, bus_err};

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [4:0] a1, input logic u1,
                               input logic [4:0] a2, input logic u2, input logic [4:0] wa,
                               input logic mr, input logic rw, input logic br,
                               input logic req, input logic ack, input logic hlt);
    rst = r; d_addr1 = a1; d_uses1 = u1; d_addr2 = a2; d_uses2 = u2; e_waddr = wa;
    e_mem_read = mr; e_reg_write = rw; br_taken = br;
    m_mem_req = req; m_mem_ack = ack; w_halt = hlt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic [8:0] expected);
    @(negedge clk);
    checkOutput(tag, {23'd0, status}, {23'd0, expected});
  endtask

  initial begin
    // Reset with hazards present: reset outputs, no counting.
    applyStimulus(1, 5'd5, 1, 0, 0, 5'd5, 1, 1, 1, 0, 0, 0);
    tick(); tick();
    checkStatus("reset_outputs", V_RST);
    checkOutput("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkOutput("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
    tick();

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkStatus("idle_run", V_RUN);
    tick();

    // Load-use via ADDR1.
    applyStimulus(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
    checkStatus("loaduse_addr1", V_LU);
    tick();
    checkOutput("loaduse_stall_cnt1", {28'd0, stall_cnt}, 32'd1);
    // Destination x0 never stalls.
    applyStimulus(0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, 0);
    checkStatus("loaduse_x0", V_RUN);
    tick();
    checkOutput("loaduse_x0_cnt", {28'd0, stall_cnt}, 32'd1);
    // Load-use via ADDR2, then same addresses with USES2 low.
    applyStimulus(0, 5'd3, 0, 5'd7, 1, 5'd7, 1, 1, 0, 0, 0, 0);
    checkStatus("loaduse_addr2", V_LU);
    tick();
    checkOutput("loaduse_addr2_cnt", {28'd0, stall_cnt}, 32'd2);
    applyStimulus(0, 5'd3, 0, 5'd7, 0, 5'd7, 1, 1, 0, 0, 0, 0);
    checkStatus("loaduse_uses2_off", V_RUN);
    applyStimulus(0, 5'd7, 1, 5'd0, 0, 5'd7, 0, 1, 0, 0, 0, 0);
    checkStatus("not_a_load", V_RUN);
    tick();

    // Branch beats load-use.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 1, 0, 0, 0);
    checkStatus("branch_over_loaduse", V_BR);
    tick();
    checkOutput("branch_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    checkOutput("branch_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // Memory wait 3 cycles with a branch pending underneath, then ACK.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      checkStatus("memwait_freeze", V_MEM);
      tick();
    end
    checkOutput("memwait_no_branch_count", {28'd0, flush_cnt}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    checkStatus("memwait_ack_cycle", V_BR);
    tick();
    checkOutput("memwait_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    checkOutput("memwait_flush_cnt", {28'd0, flush_cnt}, 32'd2);

    // Timeout: ACK held low, HALT after exactly 5 freeze cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkStatus("timeout_freeze", V_MEM);
      tick();
    end
    checkStatus("timeout_halted", V_ERR);
    tick(); tick();
    checkStatus("timeout_stays_halted", V_ERR);
    checkOutput("timeout_stall_cnt", {28'd0, stall_cnt}, 32'd8);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkStatus("timeout_reset_clears", V_RUN);
    tick();

    // W_HALT during MEM_WAIT halts without a bus error.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkStatus("whalt_in_memwait", V_HALT);
    tick();

    // Stall counter saturation.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 5'd4, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("stall_sat_reach", {28'd0, stall_cnt}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("stall_sat_hold", {28'd0, stall_cnt}, 32'd15);

    // Flush counter saturation.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) tick();
    checkOutput("flush_sat_hold", {28'd0, flush_cnt}, 32'd15);
    checkOutput("flush_sat_stall", {28'd0, stall_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
